bit_serial_addsub_ctrl: RTL and testbench



---
 rtl/bit_serial_addsub_ctrl.sv | 129 ++++++++++++
 tb/tb_bit_serial_addsub_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one shared full adder processes one bit per
// clock, LSB first, with the carry held in a register between bits.
module bit_serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_co;

    // Returns {carry, sum} of a half adder.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full adder built from two half adders, the shared one-bit datapath cell.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic [1:0] h1;
        logic [1:0] h2;
        h1 = half_add(x, y);
        h2 = half_add(h1[0], ci);
        return {h1[1] | h2[1], h2[0]};
    endfunction

    always_comb begin
        {fa_co, fa_s} = full_add(a_q[0], b_q[0], carry_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
                    b_d     = mode ? ~b : b;
                    carry_d = mode;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB; overflow is its XOR with the carry out.
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand shift registers carry no reset; they are always reloaded on acceptance.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bit_serial_addsub_ctrl.sv
// Directed bench for bit_serial_addsub_ctrl with hand-computed expected results.
module tb_bit_serial_addsub_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int n_checks = 0;
    int n_fails  = 0;

    bit_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called right after the accepting edge E0; returns right after E_WIDTH.
    task automatic wait_result(input string tag, input logic [WIDTH-1:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf);
        check({tag, "_busy_e0"}, busy, 1);
        check({tag, "_done_e0"}, done, 0);
        repeat (WIDTH - 1) tick();
        check({tag, "_done_early"}, done, 0);
        tick();
        check({tag, "_done"}, done, 1);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cout"}, cout, exp_cout);
        check({tag, "_ovf"}, overflow, exp_ovf);
    endtask

    task automatic run_op(input string tag, input logic m, input logic [WIDTH-1:0] va,
                          input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        start = 1'b1;
        mode  = m;
        a     = va;
        b     = vb;
        tick();
        start = 1'b0;
        wait_result(tag, exp_sum, exp_cout, exp_ovf);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        mode  = 1'b0;
        a     = 8'h55;
        b     = 8'h11;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", overflow, 0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        run_op("add_3c_0f", 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0);
        run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run_op("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

        // Start pulses during RUN and DONE must be ignored.
        start = 1'b1; mode = 1'b0; a = 8'h01; b = 8'h02;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        start = 1'b1; mode = 1'b1; a = 8'h11; b = 8'h22;
        tick();
        start = 1'b0;
        check("ign_busy_run", busy, 1);
        repeat (3) tick();
        check("ign_done_early", done, 0);
        tick();
        check("ign_done", done, 1);
        check("ign_sum", sum, 8'h03);
        check("ign_cout", cout, 0);
        check("ign_ovf", overflow, 0);
        start = 1'b1; mode = 1'b0; a = 8'h11; b = 8'h22;
        tick();
        start = 1'b0;
        check("ign_busy_after_done", busy, 0);
        check("ign_done_after", done, 0);
        repeat (3) tick();
        check("hold_busy", busy, 0);
        check("hold_sum", sum, 8'h03);
        check("hold_cout", cout, 0);
        check("hold_ovf", overflow, 0);

        // Reset while bit 4 is being processed aborts the operation.
        start = 1'b1; mode = 1'b0; a = 8'hF0; b = 8'h0F;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("abort_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", overflow, 0);
        for (int i = 0; i < 12; i++) begin
            check("abort_no_done", done, 0);
            tick();
        end
        run_op("post_abort", 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0);

        // start held high: operations every WIDTH+2 cycles.
        start = 1'b1; mode = 1'b0; a = 8'h10; b = 8'h20;
        tick();
        mode = 1'b1; a = 8'h40; b = 8'h10;
        wait_result("b2b_1", 8'h30, 1'b0, 1'b0);
        tick();
        check("b2b_1_gap", done, 0);
        tick();
        mode = 1'b0; a = 8'hC0; b = 8'h80;
        wait_result("b2b_2", 8'h30, 1'b1, 1'b0);
        tick();
        check("b2b_2_gap", done, 0);
        tick();
        start = 1'b0; mode = 1'b1; a = 8'h11; b = 8'h22;
        wait_result("b2b_3", 8'h40, 1'b1, 1'b1);
        tick();
        check("b2b_3_pulse", done, 0);
        check("b2b_3_busy", busy, 0);
        tick();
        check("b2b_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
